dot_max_search: RTL and testbench



---
 rtl/dot_max_search_pkg.sv | 38 +++
 rtl/dot_max_search_max_compare_reg.sv | 45 ++++
 rtl/dot_max_search.sv | 113 +++++++++++
 tb/tb_dot_max_search.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_max_search_pkg.sv
// dot_max_search_pkg: modulation codes, last-entry addresses and scan FSM states
// shared by the dot-product controller and the max-search block.
`default_nettype none

package dot_max_search_pkg;

  typedef enum logic [1:0] {
    MOD_QPSK   = 2'b00,
    MOD_QAM16  = 2'b01,
    MOD_QAM64  = 2'b10,
    MOD_QAM256 = 2'b11
  } mod_t;

  localparam int unsigned LAST_QPSK   = 0;
  localparam int unsigned LAST_QAM16  = 4;
  localparam int unsigned LAST_QAM64  = 28;
  localparam int unsigned LAST_QAM256 = 124;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Address of the final (even) entry in the result RAM for a modulation.
  function automatic int unsigned last_addr(input mod_t m);
    case (m)
      MOD_QPSK:   last_addr = LAST_QPSK;
      MOD_QAM16:  last_addr = LAST_QAM16;
      MOD_QAM64:  last_addr = LAST_QAM64;
      default:    last_addr = LAST_QAM256;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_max_search_max_compare_reg.sv
// max_compare_reg: running signed maximum with its index; the first valid
// entry after arm loads unconditionally, later ones only on strictly greater.
`default_nettype none

module max_compare_reg #(
  parameter int IDX_WIDTH  = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  valid,
  input  logic [IDX_WIDTH-1:0]  index,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [IDX_WIDTH-1:0]  best_index,
  output logic [DATA_WIDTH-1:0] best_value
);

  logic first;
  logic take;

  // Strict compare keeps the lowest index on ties.
  assign take = valid && (first || ($signed(data) > $signed(best_value)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first      <= 1'b0;
      best_index <= '0;
      best_value <= '0;
    end else begin
      if (arm) begin
        first <= 1'b1;
      end else if (valid) begin
        first <= 1'b0;
      end
      if (take) begin
        best_index <= index;
        best_value <= data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dot_max_search.sv
// dot_max_search: scans the even entries of the dot-product result RAM after
// start and reports the index/value of the largest signed metric.
`default_nettype none

module dot_max_search
  import dot_max_search_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            M,
  output logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-2:0] bestIndex,
  output logic [DATA_WIDTH-1:0] bestValue
);

  state_t                state;
  state_t                state_next;
  mod_t                  mode;
  logic [ADDR_WIDTH-1:0] last;
  logic                  start_acc;
  logic                  pipe_valid;
  logic [ADDR_WIDTH-2:0] pipe_index;

  assign last = ADDR_WIDTH'(last_addr(mode));

  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (readAddr == last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      default: begin
        done = 1'b1;
        if (start) begin
          start_acc  = 1'b1;
          state_next = ST_READ;
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The modulation is captured only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readAddr <= '0;
      mode     <= MOD_QPSK;
    end else if (start_acc) begin
      readAddr <= '0;
      mode     <= mod_t'(M);
    end else if (state == ST_READ && readAddr != last) begin
      readAddr <= readAddr + ADDR_WIDTH'(2);
    end
  end

  // Delay valid/index one cycle to line up with the synchronous RAM output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= 1'b0;
      pipe_index <= '0;
    end else begin
      pipe_valid <= (state == ST_READ);
      pipe_index <= readAddr[ADDR_WIDTH-1:1];
    end
  end

  max_compare_reg #(
    .IDX_WIDTH  (ADDR_WIDTH-1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max_compare_reg (
    .clk        (clk),
    .rst        (rst),
    .arm        (start_acc),
    .valid      (pipe_valid),
    .index      (pipe_index),
    .data       (readData),
    .best_index (bestIndex),
    .best_value (bestValue)
  );

endmodule

`default_nettype wire

// File: tb/tb_dot_max_search.sv
// tb_dot_max_search: randomized and directed scans against a behavioural
// max-search model, with literal results for the directed cases.
`default_nettype none

module tb_dot_max_search;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         M = 2'b00;
  logic [6:0]         readAddr;
  logic signed [15:0] readData = '0;
  logic               busy;
  logic               done;
  logic [5:0]         bestIndex;
  logic [15:0]        bestValue;

  logic signed [15:0] ram [128];

  int checks = 0;
  int errors = 0;

  dot_max_search #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .M         (M),
    .readAddr  (readAddr),
    .readData  (readData),
    .busy      (busy),
    .done      (done),
    .bestIndex (bestIndex),
    .bestValue (bestValue)
  );

  always #5 clk = ~clk;

  always @(posedge clk) readData <= ram[readAddr];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int last_of(input logic [1:0] m);
    case (m)
      2'b00:   return 0;
      2'b01:   return 4;
      2'b10:   return 28;
      default: return 124;
    endcase
  endfunction

  // Behavioural model: scan window [s, s+n] busy, done at s+n+1.
  int                 cyc = 0;
  int                 s = -1000;
  int                 n_ent = 0;
  int                 last = 0;
  bit                 have = 0;
  logic [5:0]         m_idx = '0, pend_idx = '0;
  logic signed [15:0] m_val = '0, pend_val = '0;

  always @(posedge clk) begin
    bit exp_busy, exp_done;
    int ea;
    cyc++;
    if (!rst) begin
      have  = 0;
      s     = -1000;
      m_idx = '0;
      m_val = '0;
    end else begin
      if (start && !(have && cyc >= s + 1 && cyc <= s + n_ent + 1)) begin
        have     = 1;
        s        = cyc;
        last     = last_of(M);
        n_ent    = last / 2 + 1;
        pend_idx = '0;
        pend_val = ram[0];
        for (int i = 1; i < n_ent; i++) begin
          if (ram[2*i] > pend_val) begin
            pend_val = ram[2*i];
            pend_idx = 6'(i);
          end
        end
      end
      if (have && cyc == s + n_ent + 1) begin
        m_idx = pend_idx;
        m_val = pend_val;
      end
    end
    #1;
    exp_busy = have && cyc >= s && cyc <= s + n_ent;
    exp_done = have && cyc == s + n_ent + 1;
    ea = have ? ((2 * (cyc - s) < last) ? 2 * (cyc - s) : last) : 0;
    chk("busy", 16'(busy), 16'(exp_busy));
    chk("done", 16'(done), 16'(exp_done));
    chk("readAddr", 16'(readAddr), 16'(ea));
    if (!exp_busy) begin
      chk("bestIndex", 16'(bestIndex), 16'(m_idx));
      chk("bestValue", bestValue, m_val);
    end
  end

  // Starts a scan (from the current negedge when from_done is set) and
  // returns the number of edges from acceptance until done is seen.
  task automatic scan(input logic [1:0] mode, input bit repulse, input bit from_done,
                      output int lat);
    if (!from_done) @(negedge clk);
    start = 1'b1;
    M     = mode;
    @(negedge clk);
    start = repulse;
    M     = ~mode;
    lat   = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    start = 1'b0;
    if (!done) chk("scan_timeout", 16'(done), 16'd1);
  endtask

  task automatic expect_result(input string name, input int lat, input int exp_lat,
                               input int idx, input logic [15:0] val);
    chk({name, "_latency"}, 16'(lat), 16'(exp_lat));
    chk({name, "_index"}, 16'(bestIndex), 16'(idx));
    chk({name, "_value"}, bestValue, val);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 128; i++) ram[i] = 16'($urandom);

    @(negedge clk);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_addr", 16'(readAddr), 16'd0);
    chk("reset_index", 16'(bestIndex), 16'd0);
    chk("reset_value", bestValue, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    ram[0] = -16'sd5;
    scan(2'b00, 0, 0, lat);
    expect_result("qpsk", lat, 2, 0, 16'hFFFB);

    ram[0] = 16'sd10; ram[2] = 16'sd30; ram[4] = 16'sd20;
    scan(2'b01, 0, 0, lat);
    expect_result("qam16", lat, 4, 1, 16'd30);

    for (int k = 0; k < 15; k++) ram[2*k] = 16'sd7;
    scan(2'b10, 0, 0, lat);
    expect_result("qam64_tie", lat, 16, 0, 16'd7);

    for (int k = 0; k < 15; k++) ram[2*k] = 16'sh8000;
    ram[28] = 16'sh8001;
    scan(2'b10, 0, 0, lat);
    expect_result("qam64_neg", lat, 16, 14, 16'h8001);

    for (int k = 0; k < 63; k++) ram[2*k] = 16'(k);
    ram[124] = 16'sd1000;
    scan(2'b11, 0, 0, lat);
    expect_result("qam256", lat, 64, 62, 16'd1000);
    chk("qam256_last_addr", 16'(readAddr), 16'd124);

    ram[0] = 16'sd10; ram[2] = 16'sd30; ram[4] = 16'sd20;
    scan(2'b01, 1, 0, lat);
    expect_result("repulse", lat, 4, 1, 16'd30);
    scan(2'b00, 0, 1, lat);
    expect_result("back_to_back", lat, 2, 0, 16'd10);

    @(negedge clk);
    start = 1'b1; M = 2'b10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_addr", 16'(readAddr), 16'd0);
    chk("abort_index", 16'(bestIndex), 16'd0);
    chk("abort_value", bestValue, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 15; k++) ram[2*k] = 16'(3 * k);
    ram[18] = 16'sd500;
    scan(2'b10, 0, 0, lat);
    expect_result("after_abort", lat, 16, 9, 16'd500);

    for (int r = 0; r < 30; r++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) begin
        int c;
        c = $urandom_range(0, 7);
        if (c == 0)      ram[2*i] = 16'sh8000;
        else if (c == 1) ram[2*i] = 16'sh7FFF;
        else if (c < 5)  ram[2*i] = 16'($urandom_range(0, 3)) - 16'sd1;
        else             ram[2*i] = 16'($urandom);
        ram[2*i+1] = 16'sh7FFF;
      end
      scan(2'(mode), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) && done, lat);
      chk("rand_latency", 16'(lat), 16'(last_of(2'(mode)) / 2 + 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
